wb2sdrc_burst: RTL and testbench
================================

Name: wb2sdrc_burst

Overview:
Single-clock Wishbone B3 slave to SDRAM-controller request/data bridge, the parametrised successor of the dual-clock wb2sdrc bridge. Supports Wishbone incrementing bursts (wb_cti_i) and converts each into one multi-word SDRAM request with a computed length. Uses synchronous command-free write and read data buffers; it sits between the Wishbone bus matrix and the SDRAM controller when both run on the same clock.

Parameters:
DW, 32, Wishbone/SDRAM data width in bits (multiple of 8).
AW, 26, word address width.
LW, 9, width of sdr_req_len.
MAX_BURST, 8, maximum beats per SDRAM request (2..2**(LW)-1).
WF_DEPTH, 8, write data buffer depth in entries; must be >= MAX_BURST and a power of 2.
RF_DEPTH, 8, read data buffer depth in entries; must be >= MAX_BURST and a power of 2.

Ports:
wb_clk_i  in  1  single clock for the bus and the controller side
wb_rst_i  in  1  asynchronous, active-high reset
wb_stb_i / wb_cyc_i / wb_we_i  in  1 each  Wishbone strobe, cycle, write enable
wb_addr_i  in  AW  word address
wb_dat_i  in  DW  write data
wb_sel_i  in  DW/8  byte selects
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst
wb_dat_o  out  DW  read data
wb_ack_o  out  1  beat acknowledge
sdr_req  out  1  request valid
sdr_req_addr  out  AW  start word address
sdr_req_len  out  LW  beat count
sdr_req_wr_n  out  1  0 = write, 1 = read
sdr_req_ack  in  1  controller accepts request
sdr_wr_next  in  1  controller pops one write beat
sdr_wr_data  out  DW  write data head
sdr_wr_en_n  out  DW/8  active-low byte enables, equal to ~wb_sel_i of the beat
sdr_rd_valid  in  1  read beat valid
sdr_last_rd  in  1  last beat of the request
sdr_rd_data  in  DW  read data

Behaviour:
- Reset, asynchronous on wb_rst_i high: state IDLE, both buffers empty, beat counter 0. Outputs: wb_ack_o=0, sdr_req=0, sdr_req_addr=0, sdr_req_len=0, sdr_req_wr_n=1. wb_dat_o and sdr_wr_data are don't-care.
- FSM states: IDLE, WR_COLLECT, WR_REQ, WR_FLUSH, RD_REQ, RD_DATA, RD_DRAIN.
- IDLE with stb&cyc&we:
  - Capture wb_addr_i into sdr_req_addr, clear the beat counter, go to WR_COLLECT.
  - No ack in this cycle, so the first beat has one cycle of latency.
- WR_COLLECT:
  - wb_ack_o = stb&cyc&we & !wfull. This is combinational from the inputs and the buffer flags.
  - Each acked beat pushes {~sel, dat} and increments the counter.
  - Go to WR_REQ on any of: an acked beat with cti != 010; counter+1 == MAX_BURST; or cyc low while counter > 0.
- WR_REQ:
  - sdr_req=1, sdr_req_wr_n=0, sdr_req_len=counter.
  - Hold every field stable until sdr_req_ack is sampled high, then go to WR_FLUSH.
- WR_FLUSH:
  - Each sdr_wr_next pops one beat; the buffer output is first-word-fall-through.
  - Go to IDLE when the buffer is empty.
  - A burst longer than MAX_BURST resumes in IDLE with the next address. Example: a 10-beat burst becomes requests of 8 and 2 beats.
- IDLE with stb&cyc&!we:
  - Capture the address, set sdr_req_len = MAX_BURST if cti==010, else 1. Go to RD_REQ.
  - RD_REQ behaves like WR_REQ with sdr_req_wr_n=1; on sdr_req_ack go to RD_DATA.
- Read buffer: sdr_rd_valid pushes {sdr_last_rd, sdr_rd_data}. The buffer never overflows because RF_DEPTH >= MAX_BURST.
- RD_DATA:
  - wb_ack_o = stb&cyc&!we & !rempty. wb_dat_o = head data; an ack pops the head.
  - Popping an entry with last=1 goes to IDLE.
  - Acked beat with cti==111 before last, or cyc low: go to RD_DRAIN.
- RD_DRAIN:
  - Pop every cycle the buffer is non-empty, without ack.
  - Go to IDLE after the entry with last=1 is popped.
- Simultaneous push and pop on the same buffer in the same cycle keep the count unchanged. Full and empty flags are registered.
- sdr_req is never high in IDLE, WR_COLLECT, WR_FLUSH, RD_DATA or RD_DRAIN.
- Reset mid-operation discards all buffered data. The controller side is reset by the same signal.

Optional Feature:
WB2SDRC_BURST_EN
- Defined: cti-driven bursts as described above.
- Undefined: wb_cti_i is ignored. Every transfer is a single beat with sdr_req_len=1, and WR_COLLECT exits after one acked beat.

Decomposition:
- Package wb2sdrc_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111;
  - the FSM state enum;
  - the helper function clog2 for buffer pointer widths.
- One sub-module, sync_fifo: parametrised width and depth, first-word-fall-through, registered full/empty. It is instantiated twice, for write data (DW+DW/8 bits wide) and read data (DW+1 bits wide).

Test Plan:
- Classic write, addr 0x100, data 0xDEADBEEF, sel 4'b0011 -> one request: addr 0x100, len 1, wr_n 0. On sdr_wr_next: sdr_wr_data 0xDEADBEEF, sdr_wr_en_n 4'b1100.
- 4-beat incrementing write at 0x200, last beat cti=111 -> exactly one request, len 4, after 4 acks. Data is popped in order.
- 10-beat incrementing write at 0x300 -> requests len 8 at 0x300, then len 2 at 0x308.
- 8-beat incrementing read at 0x400; controller returns 8 beats with sdr_last_rd on beat 8 -> 8 acks with matching data, FSM back in IDLE.
- Read burst where the master drops cyc after 3 acks -> the remaining 5 beats are drained without ack, FSM returns to IDLE, and the next classic read is served correctly.
- Assert wb_rst_i during WR_FLUSH with 3 beats left -> sdr_req=0 and both buffers empty immediately. A new write after reset produces len 1.

Source files
------------

// File: rtl/wb2sdrc_pkg.sv
// Shared definitions for the single-clock Wishbone to SDRAM-controller burst bridge:
// cycle-type codes, the bridge FSM state type and a pointer-width helper.
package wb2sdrc_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_REQ,
    WR_FLUSH,
    RD_REQ,
    RD_DATA,
    RD_DRAIN
  } state_t;

  // Number of address bits needed to index 'value' entries
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb2sdrc_burst_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the fill level unchanged.
module sync_fifo
  import wb2sdrc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic [PW:0]      w_countNext;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push & ~r_full;
  assign w_doPop  = i_pop & ~r_empty;

  // Next fill level from the qualified push/pop pair
  always_comb begin
    w_countNext = r_count;
    case ({w_doPush, w_doPop})
      2'b10:   w_countNext = r_count + (PW+1)'(1);
      2'b01:   w_countNext = r_count - (PW+1)'(1);
      default: w_countNext = r_count;
    endcase
  end

  // Pointers, fill level and flags; flags are derived from the next level so they stay registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == (PW+1)'(DEPTH));
      r_empty <= (w_countNext == '0);
    end
  end

  // Storage array; contents need no reset because the flags gate every read
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/wb2sdrc_burst.sv
// Single-clock Wishbone B3 slave to SDRAM-controller request/data bridge.
// Wishbone bursts are collected into one multi-word controller request when
// WB2SDRC_BURST_EN is defined; otherwise cycle type is ignored and every
// transfer is a single-beat request.
module wb2sdrc_burst
  import wb2sdrc_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int LW        = 9,
  parameter int MAX_BURST = 8,
  parameter int WF_DEPTH  = 8,
  parameter int RF_DEPTH  = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [2:0]      wb_cti_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            sdr_req,
  output logic [AW-1:0]   sdr_req_addr,
  output logic [LW-1:0]   sdr_req_len,
  output logic            sdr_req_wr_n,
  input  logic            sdr_req_ack,
  input  logic            sdr_wr_next,
  output logic [DW-1:0]   sdr_wr_data,
  output logic [DW/8-1:0] sdr_wr_en_n,
  input  logic            sdr_rd_valid,
  input  logic            sdr_last_rd,
  input  logic [DW-1:0]   sdr_rd_data
);

  localparam int SW  = DW / 8;
  localparam int WFW = DW + SW;
  localparam int RFW = DW + 1;
  localparam logic [LW-1:0] MaxLen = LW'(MAX_BURST);
  localparam logic [LW-1:0] OneLen = LW'(1);

  state_t          r_state;
  logic            r_req;
  logic [AW-1:0]   r_reqAddr;
  logic [LW-1:0]   r_reqLen;
  logic            r_reqWrN;
  logic [LW-1:0]   r_beatCnt;

  logic            w_wrStb;
  logic            w_rdStb;
  logic            w_incr;
  logic            w_end;
  logic            w_ack;
  logic [LW-1:0]   w_cntNext;

  logic            w_wPush;
  logic            w_wPop;
  logic            w_wFull;
  logic            w_wEmpty;
  logic [WFW-1:0]  w_wHead;

  logic            w_rPush;
  logic            w_rPop;
  logic            w_rFull;
  logic            w_rEmpty;
  logic [RFW-1:0]  w_rHead;
  logic            w_rHeadLast;

  assign w_wrStb   = wb_stb_i & wb_cyc_i & wb_we_i;
  assign w_rdStb   = wb_stb_i & wb_cyc_i & ~wb_we_i;
  assign w_cntNext = r_beatCnt + OneLen;

`ifdef WB2SDRC_BURST_EN
  assign w_incr = (wb_cti_i == CTI_INCR);
  assign w_end  = (wb_cti_i == CTI_END);
`else
  logic [2:0] w_unusedCti;
  assign w_unusedCti = wb_cti_i;
  assign w_incr      = 1'b0;
  assign w_end       = 1'b0;
`endif

  // Beat acknowledge is combinational so a buffered beat completes in the same cycle it is offered
  always_comb begin
    w_ack = 1'b0;
    case (r_state)
      WR_COLLECT: w_ack = w_wrStb & ~w_wFull;
      RD_DATA:    w_ack = w_rdStb & ~w_rEmpty;
      default:    w_ack = 1'b0;
    endcase
  end

  assign w_wPush     = (r_state == WR_COLLECT) & w_ack;
  assign w_wPop      = sdr_wr_next & ~w_wEmpty;
  assign w_rPush     = sdr_rd_valid & ~w_rFull;
  assign w_rPop      = ((r_state == RD_DATA) & w_ack) | ((r_state == RD_DRAIN) & ~w_rEmpty);
  assign w_rHeadLast = w_rHead[DW];

  // Bridge FSM; every controller request field is registered and held until accepted
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_reqAddr <= '0;
      r_reqLen  <= '0;
      r_reqWrN  <= 1'b1;
      r_beatCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wrStb) begin
            r_reqAddr <= wb_addr_i;
            r_beatCnt <= '0;
            r_state   <= WR_COLLECT;
          end else if (w_rdStb) begin
            r_reqAddr <= wb_addr_i;
            r_reqLen  <= w_incr ? MaxLen : OneLen;
            r_reqWrN  <= 1'b1;
            r_req     <= 1'b1;
            r_state   <= RD_REQ;
          end
        end
        WR_COLLECT: begin
          if (w_ack) begin
            r_beatCnt <= w_cntNext;
            if (!w_incr || (w_cntNext == MaxLen)) begin
              r_reqLen <= w_cntNext;
              r_reqWrN <= 1'b0;
              r_req    <= 1'b1;
              r_state  <= WR_REQ;
            end
          end else if (!wb_cyc_i) begin
            if (r_beatCnt != '0) begin
              r_reqLen <= r_beatCnt;
              r_reqWrN <= 1'b0;
              r_req    <= 1'b1;
              r_state  <= WR_REQ;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        WR_REQ: begin
          if (sdr_req_ack) begin
            r_req   <= 1'b0;
            r_state <= WR_FLUSH;
          end
        end
        WR_FLUSH: begin
          if (w_wEmpty) begin
            r_state <= IDLE;
          end
        end
        RD_REQ: begin
          if (sdr_req_ack) begin
            r_req   <= 1'b0;
            r_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_ack) begin
            if (w_rHeadLast) begin
              r_state <= IDLE;
            end else if (w_end) begin
              r_state <= RD_DRAIN;
            end
          end else if (!wb_cyc_i) begin
            r_state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (!w_rEmpty && w_rHeadLast) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WFW),
    .DEPTH (WF_DEPTH)
  ) u_wrFifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_wPush),
    .i_data  ({~wb_sel_i, wb_dat_i}),
    .i_pop   (w_wPop),
    .o_data  (w_wHead),
    .o_full  (w_wFull),
    .o_empty (w_wEmpty)
  );

  sync_fifo #(
    .WIDTH (RFW),
    .DEPTH (RF_DEPTH)
  ) u_rdFifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_rPush),
    .i_data  ({sdr_last_rd, sdr_rd_data}),
    .i_pop   (w_rPop),
    .o_data  (w_rHead),
    .o_full  (w_rFull),
    .o_empty (w_rEmpty)
  );

  assign wb_ack_o     = w_ack;
  assign wb_dat_o     = w_rHead[DW-1:0];
  assign sdr_req      = r_req;
  assign sdr_req_addr = r_reqAddr;
  assign sdr_req_len  = r_reqLen;
  assign sdr_req_wr_n = r_reqWrN;
  assign sdr_wr_data  = w_wHead[DW-1:0];
  assign sdr_wr_en_n  = w_wHead[WFW-1:DW];

endmodule

// File: tb/tb_wb2sdrc_burst.sv
// Testbench for wb2sdrc_burst: a Wishbone master driven from a vector table,
// a controller model that accepts requests, pops write beats and returns read
// beats, and scoreboards of expected requests and write beats.
// Expectations follow WB2SDRC_BURST_EN in the same way as the design.
module tb_wb2sdrc_burst;
  import wb2sdrc_pkg::*;

  localparam int DW        = 32;
  localparam int AW        = 26;
  localparam int LW        = 9;
  localparam int MAX_BURST = 8;
  localparam int SW        = DW / 8;

`ifdef WB2SDRC_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_stb_i;
  logic            wb_cyc_i;
  logic            wb_we_i;
  logic [AW-1:0]   wb_addr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [SW-1:0]   wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            sdr_req;
  logic [AW-1:0]   sdr_req_addr;
  logic [LW-1:0]   sdr_req_len;
  logic            sdr_req_wr_n;
  logic            sdr_req_ack;
  logic            sdr_wr_next;
  logic [DW-1:0]   sdr_wr_data;
  logic [SW-1:0]   sdr_wr_en_n;
  logic            sdr_rd_valid;
  logic            sdr_last_rd;
  logic [DW-1:0]   sdr_rd_data;

  always #5 clk = ~clk;

  wb2sdrc_burst #(
    .DW(DW), .AW(AW), .LW(LW), .MAX_BURST(MAX_BURST), .WF_DEPTH(8), .RF_DEPTH(8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_cti_i     (wb_cti_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .sdr_req      (sdr_req),
    .sdr_req_addr (sdr_req_addr),
    .sdr_req_len  (sdr_req_len),
    .sdr_req_wr_n (sdr_req_wr_n),
    .sdr_req_ack  (sdr_req_ack),
    .sdr_wr_next  (sdr_wr_next),
    .sdr_wr_data  (sdr_wr_data),
    .sdr_wr_en_n  (sdr_wr_en_n),
    .sdr_rd_valid (sdr_rd_valid),
    .sdr_last_rd  (sdr_last_rd),
    .sdr_rd_data  (sdr_rd_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          wrN;
  } req_t;

  typedef struct {
    logic          isWrite;
    logic [AW-1:0] addr;
    int            beats;
    int            dropAfter;
    logic [DW-1:0] data0;
    logic [SW-1:0] sel0;
    int            expReqs;
  } vec_t;

  req_t             expReqQ[$];
  logic [SW+DW-1:0] expWrQ[$];
  vec_t             vecs[8];

  int            compared   = 0;
  int            mismatched = 0;
  int            reqSeen    = 0;
  int            wrLeft     = 0;
  int            rdLeft     = 0;
  int            rdIdx      = 0;
  int            wrPopped   = 0;
  int            popLimit   = 1000000;
  logic [AW-1:0] rdAddr     = '0;

  // Read data the controller model returns for a word address
  function automatic logic [DW-1:0] rdPattern(input logic [AW-1:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return {lo, ~lo} ^ 32'h13579BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected controller requests for one master transfer
  task automatic buildExpected(input logic isWrite, input logic [AW-1:0] addr, input int beats, input int dropAfter);
    int   n;
    int   done;
    int   len;
    req_t e;
    n    = (dropAfter >= 0) ? dropAfter : beats;
    done = 0;
    while (done < n) begin
      if (isWrite) begin
        len = BURST_ON ? ((n - done > MAX_BURST) ? MAX_BURST : n - done) : 1;
      end else begin
        len = (BURST_ON && beats > 1 && done < beats - 1) ? MAX_BURST : 1;
      end
      e.addr = addr + AW'(done);
      e.len  = LW'(len);
      e.wrN  = ~isWrite;
      expReqQ.push_back(e);
      done = done + ((len < n - done) ? len : n - done);
    end
  endtask

  // Wishbone master: one transfer of 'beats' beats, optionally dropping cyc after 'dropAfter' acks
  task automatic applyStimulus(input logic isWrite, input logic [AW-1:0] addr, input int beats,
                               input int dropAfter, input logic [DW-1:0] data0, input logic [SW-1:0] sel0);
    int            nAck;
    int            acked;
    int            waitCnt;
    bit            timedOut;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    nAck     = (dropAfter >= 0) ? dropAfter : beats;
    acked    = 0;
    timedOut = 1'b0;
    while (acked < nAck && !timedOut) begin
      @(negedge clk);
      d = data0 + (DW'(acked) * 32'h01010101);
      s = sel0 ^ SW'(acked);
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = isWrite;
      wb_addr_i = addr + AW'(acked);
      wb_dat_i  = d;
      wb_sel_i  = s;
      wb_cti_i  = (beats == 1) ? CTI_CLASSIC : ((acked < beats - 1) ? CTI_INCR : CTI_END);
      #1;
      waitCnt = 0;
      while (wb_ack_o !== 1'b1 && !timedOut) begin
        waitCnt++;
        if (waitCnt > 300) begin
          timedOut = 1'b1;
          compared++;
          mismatched++;
          $display("[TB] FAIL ackTimeout: beat %0d at 0x%0h got no ack, required one within 300 cycles", acked, wb_addr_i);
        end else begin
          @(negedge clk);
          #1;
        end
      end
      if (!timedOut) begin
        if (isWrite) begin
          expWrQ.push_back({~s, d});
        end else begin
          checkOutput("rdData", 64'(wb_dat_o), 64'(rdPattern(wb_addr_i)));
        end
        acked++;
      end
    end
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_cti_i = CTI_CLASSIC;
  endtask

  // Controller model: accepts requests, pops write beats, returns read beats
  task automatic controllerLoop();
    req_t             e;
    logic [SW+DW-1:0] w;
    forever begin
      @(negedge clk);
      sdr_req_ack  = 1'b0;
      sdr_wr_next  = 1'b0;
      sdr_rd_valid = 1'b0;
      sdr_last_rd  = 1'b0;
      if (rst) begin
        wrLeft = 0;
        rdLeft = 0;
        expReqQ.delete();
        expWrQ.delete();
      end else begin
        if (wrLeft > 0 && wrPopped < popLimit) begin
          if (expWrQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wrBeat: got beat 0x%0h, expected no further write beat", sdr_wr_data);
          end else begin
            w = expWrQ.pop_front();
            checkOutput("wrData", 64'(sdr_wr_data), 64'(w[DW-1:0]));
            checkOutput("wrEnN", 64'(sdr_wr_en_n), 64'(w[SW+DW-1:DW]));
          end
          sdr_wr_next = 1'b1;
          wrLeft--;
          wrPopped++;
        end
        if (rdLeft > 0) begin
          sdr_rd_valid = 1'b1;
          sdr_rd_data  = rdPattern(rdAddr + AW'(rdIdx));
          sdr_last_rd  = (rdLeft == 1);
          rdIdx++;
          rdLeft--;
        end
        if (sdr_req && wrLeft == 0 && rdLeft == 0) begin
          sdr_req_ack = 1'b1;
          reqSeen++;
          if (expReqQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL reqUnexpected: got request at 0x%0h len %0d, expected none", sdr_req_addr, sdr_req_len);
          end else begin
            e = expReqQ.pop_front();
            checkOutput("reqAddr", 64'(sdr_req_addr), 64'(e.addr));
            checkOutput("reqLen", 64'(sdr_req_len), 64'(e.len));
            checkOutput("reqWrN", 64'(sdr_req_wr_n), 64'(e.wrN));
          end
          if (!sdr_req_wr_n) begin
            wrLeft = int'(sdr_req_len);
          end else begin
            rdLeft = int'(sdr_req_len);
            rdAddr = sdr_req_addr;
            rdIdx  = 0;
          end
        end
      end
    end
  endtask

  task automatic waitIdle();
    int cnt;
    cnt = 0;
    while ((expReqQ.size() != 0 || expWrQ.size() != 0 || wrLeft != 0 || rdLeft != 0) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 500) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleTimeout: %0d requests and %0d write beats outstanding, expected 0", expReqQ.size(), expWrQ.size());
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int base;
    int cnt;
    int beats;

    rst          = 1'b1;
    wb_stb_i     = 1'b0;
    wb_cyc_i     = 1'b0;
    wb_we_i      = 1'b0;
    wb_addr_i    = '0;
    wb_dat_i     = '0;
    wb_sel_i     = '0;
    wb_cti_i     = CTI_CLASSIC;
    sdr_req_ack  = 1'b0;
    sdr_wr_next  = 1'b0;
    sdr_rd_valid = 1'b0;
    sdr_last_rd  = 1'b0;
    sdr_rd_data  = '0;

    vecs[0] = '{1'b1, 26'h100, 1,  -1, 32'hDEADBEEF, 4'b0011, 1};
    vecs[1] = '{1'b1, 26'h200, 4,  -1, 32'h11223344, 4'b1111, BURST_ON ? 1 : 4};
    vecs[2] = '{1'b1, 26'h300, 10, -1, 32'hA0B0C0D0, 4'b0101, BURST_ON ? 2 : 10};
    vecs[3] = '{1'b0, 26'h400, 8,  -1, 32'h0,        4'b1111, BURST_ON ? 1 : 8};
    vecs[4] = '{1'b0, 26'h500, 8,   3, 32'h0,        4'b1111, BURST_ON ? 1 : 3};
    vecs[5] = '{1'b0, 26'h600, 1,  -1, 32'h0,        4'b1111, 1};
    vecs[6] = '{1'b0, 26'h800, 4,  -1, 32'h0,        4'b1111, BURST_ON ? 1 : 4};
    vecs[7] = '{1'b1, 26'h700, 3,  -1, 32'hCAFEF00D, 4'b1000, BURST_ON ? 1 : 3};

    fork
      controllerLoop();
    join_none

    repeat (3) @(negedge clk);
    checkOutput("rstReq", 64'(sdr_req), 64'(0));
    checkOutput("rstAddr", 64'(sdr_req_addr), 64'(0));
    checkOutput("rstLen", 64'(sdr_req_len), 64'(0));
    checkOutput("rstWrN", 64'(sdr_req_wr_n), 64'(1));
    checkOutput("rstAck", 64'(wb_ack_o), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      base = reqSeen;
      buildExpected(vecs[i].isWrite, vecs[i].addr, vecs[i].beats, vecs[i].dropAfter);
      applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].beats, vecs[i].dropAfter, vecs[i].data0, vecs[i].sel0);
      waitIdle();
      checkOutput($sformatf("reqCount%0d", i), 64'(reqSeen - base), 64'(vecs[i].expReqs));
      checkOutput($sformatf("reqLowAfter%0d", i), 64'(sdr_req), 64'(0));
      checkOutput($sformatf("ackLowAfter%0d", i), 64'(wb_ack_o), 64'(0));
    end

    // Reset while write beats are still waiting in the write buffer
    beats    = BURST_ON ? 4 : 1;
    popLimit = wrPopped + (BURST_ON ? 1 : 0);
    buildExpected(1'b1, 26'hA00, beats, -1);
    applyStimulus(1'b1, 26'hA00, beats, -1, 32'h55AA55AA, 4'b1111);
    cnt = 0;
    while ((expReqQ.size() != 0 || wrPopped < popLimit) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL flushTimeout: write at 0xa00 not accepted, required acceptance within 200 cycles");
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstReq", 64'(sdr_req), 64'(0));
    checkOutput("midRstAddr", 64'(sdr_req_addr), 64'(0));
    checkOutput("midRstLen", 64'(sdr_req_len), 64'(0));
    checkOutput("midRstWrN", 64'(sdr_req_wr_n), 64'(1));
    checkOutput("midRstAck", 64'(wb_ack_o), 64'(0));
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    popLimit = 1000000;
    @(negedge clk);

    base = reqSeen;
    buildExpected(1'b1, 26'h900, 1, -1);
    applyStimulus(1'b1, 26'h900, 1, -1, 32'h12345678, 4'b1111);
    waitIdle();
    checkOutput("postRstReqCount", 64'(reqSeen - base), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
